// File: rtl/vga_pixel_pkg.sv
// Shared types and constants for the pixel frame-buffer responder.
package vga_pixel_pkg;

  typedef logic [15:0] pixel_t;

  localparam logic [31:0]  PIXEL_BASE_ADDR      = 32'h0800_0000;
  localparam pixel_t       PIXEL_FILL_COLOR     = 16'h0000;
  localparam int unsigned  PIXEL_RD_LATENCY_MIN = 1;
  localparam int unsigned  PIXEL_RD_LATENCY_MAX = 8;

endpackage

// File: rtl/pixel_ram_sp.sv
// Single-port 2^ADDR_W x 16 pixel RAM with byte enables and a registered read port.
module pixel_ram_sp
  import vga_pixel_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [1:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  pixel_t            wdata_i,
  output pixel_t            rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  pixel_t mem_q [DEPTH];
  pixel_t rdata_q;

  // Read data holds between reads; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_buffer_responder.sv
// Avalon-MM pipelined read slave for pixel DMA plus a CPU/fill write port sharing one RAM.
// Optional statistics counters: define PIXEL_RESPONDER_STATS_EN.
module pixel_buffer_responder
  import vga_pixel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = PIXEL_BASE_ADDR,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter pixel_t      FILL_COLOR   = PIXEL_FILL_COLOR
) (
  input  logic              sys_clk_clk,
  input  logic              sys_reset_reset_n,
  input  logic [31:0]       pixel_dma_slave_address,
  input  logic              pixel_dma_slave_read,
  input  logic              pixel_dma_slave_lock,
  output logic              pixel_dma_slave_waitrequest,
  output logic              pixel_dma_slave_readdatavalid,
  output logic [15:0]       pixel_dma_slave_readdata,
  input  logic [ADDR_W-1:0] pixel_wr_address,
  input  logic              pixel_wr_write,
  input  logic [15:0]       pixel_wr_writedata,
  input  logic [1:0]        pixel_wr_byteenable,
`ifdef PIXEL_RESPONDER_STATS_EN
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_read_stalls,
`endif
  output logic              pixel_wr_waitrequest
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREG     = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

  logic [31:0]          byte_off_c;
  logic [31:0]          word_off_c;
  logic                 in_range_c;
  logic                 lock_hold_c;
  logic                 grant_rd_c;
  logic                 grant_wr_c;
  logic                 ram_re_c;
  logic [ADDR_W-1:0]    ram_addr_c;
  logic                 lock_hold_q, lock_hold_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic                 oor_q, oor_d;
  pixel_t               ram_rdata;
  pixel_t               beat_c;
  pixel_t               dat_q [NREG];

  assign byte_off_c = pixel_dma_slave_address - BASE_ADDR;
  assign word_off_c = byte_off_c >> 1;
  assign in_range_c = (pixel_dma_slave_address >= BASE_ADDR) &&
                      (word_off_c[31:ADDR_W] == '0);

  // Arbitration: an effective lock needs both the held flag and lock still asserted.
  always_comb begin
    lock_hold_c = lock_hold_q & pixel_dma_slave_lock;
    grant_rd_c  = pixel_dma_slave_read &
                  (~in_range_c | lock_hold_c | ~pixel_wr_write |
                   (starve_q < STARVE_W'(STARVE_LIMIT)));
    grant_wr_c  = pixel_wr_write & ~lock_hold_c & ~(grant_rd_c & in_range_c);
    ram_re_c    = grant_rd_c & in_range_c;
    ram_addr_c  = ram_re_c ? word_off_c[ADDR_W-1:0] : pixel_wr_address;

    lock_hold_d = pixel_dma_slave_lock & (lock_hold_q | grant_rd_c);
    starve_d    = starve_q;
    if (!pixel_wr_write || grant_wr_c) begin
      starve_d = '0;
    end else if (starve_q < STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    vld_d = RD_LATENCY'({vld_q, grant_rd_c});
    oor_d = grant_rd_c & ~in_range_c;
  end

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      lock_hold_q <= 1'b0;
      starve_q    <= '0;
      vld_q       <= '0;
      oor_q       <= 1'b0;
    end else begin
      lock_hold_q <= lock_hold_d;
      starve_q    <= starve_d;
      vld_q       <= vld_d;
      oor_q       <= oor_d;
    end
  end

  pixel_ram_sp #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (sys_clk_clk),
    .re_i    (ram_re_c),
    .we_i    (grant_wr_c),
    .be_i    (pixel_wr_byteenable),
    .addr_i  (ram_addr_c),
    .wdata_i (pixel_wr_writedata),
    .rdata_o (ram_rdata)
  );

  assign beat_c = oor_q ? FILL_COLOR : ram_rdata;

  // Each data stage only loads when a beat arrives, so the last stage holds readdata.
  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      dat_q[0] <= '0;
    end else if (vld_q[0]) begin
      dat_q[0] <= beat_c;
    end
  end

  for (genvar k = 1; k < NREG; k++) begin : g_stage
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
      if (!sys_reset_reset_n) begin
        dat_q[k] <= '0;
      end else if (vld_q[k]) begin
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign pixel_dma_slave_readdata = vld_q[0] ? beat_c : dat_q[0];
  end else begin : g_latn
    assign pixel_dma_slave_readdata = dat_q[NREG-1];
  end

  assign pixel_dma_slave_readdatavalid = vld_q[RD_LATENCY-1];
  assign pixel_dma_slave_waitrequest   = pixel_dma_slave_read & ~grant_rd_c;
  assign pixel_wr_waitrequest          = pixel_wr_write & ~grant_wr_c;

`ifdef PIXEL_RESPONDER_STATS_EN
  logic [31:0] stat_reads_q;
  logic [31:0] stat_stalls_q;

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      stat_reads_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (grant_rd_c) stat_reads_q <= stat_reads_q + 32'd1;
      if (pixel_dma_slave_waitrequest) stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign stat_reads       = stat_reads_q;
  assign stat_read_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_pixel_buffer_responder.sv
// Randomized bench for pixel_buffer_responder against a cycle-scheduled reference model.
module tb_pixel_buffer_responder;

  localparam logic [31:0] BASE = 32'h0800_0000;
  localparam int          AW   = 17;
  localparam int          LAT  = 2;
  localparam int          SLIM = 8;
  localparam logic [15:0] FILL = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   addr = '0;
  logic          rd = 1'b0;
  logic          lock = 1'b0;
  logic          rd_wait;
  logic          rdv;
  logic [15:0]   rdata;
  logic [AW-1:0] wr_addr = '0;
  logic          wr = 1'b0;
  logic [15:0]   wdata = '0;
  logic [1:0]    be = 2'b11;
  logic          wr_wait;
`ifdef PIXEL_RESPONDER_STATS_EN
  logic [31:0]   stat_reads;
  logic [31:0]   stat_read_stalls;
`endif

  always #5 clk = ~clk;

  pixel_buffer_responder dut (
    .sys_clk_clk                   (clk),
    .sys_reset_reset_n             (rst_n),
    .pixel_dma_slave_address       (addr),
    .pixel_dma_slave_read          (rd),
    .pixel_dma_slave_lock          (lock),
    .pixel_dma_slave_waitrequest   (rd_wait),
    .pixel_dma_slave_readdatavalid (rdv),
    .pixel_dma_slave_readdata      (rdata),
    .pixel_wr_address              (wr_addr),
    .pixel_wr_write                (wr),
    .pixel_wr_writedata            (wdata),
    .pixel_wr_byteenable           (be),
`ifdef PIXEL_RESPONDER_STATS_EN
    .stat_reads                    (stat_reads),
    .stat_read_stalls              (stat_read_stalls),
`endif
    .pixel_wr_waitrequest          (wr_wait)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } beat_t;

  logic [15:0] mem_m [int];
  beat_t       exp_q[$];
  logic [15:0] seen_d[$];
  int          seen_c[$];
  int          acc_c[$];
  int          cyc;
  bit          hold_m;
  int          starve_m;
  logic [15:0] last_m;
  int          reads_m, stalls_m;
  bit          obs_rdw, obs_wrw;
  int          errors, checks;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_idle();
    rd = 1'b0; lock = 1'b0; wr = 1'b0; be = 2'b11;
  endtask

  // One clock cycle: sample at mid-cycle, compare, advance the model, move past the edge.
  task automatic step();
    bit [31:0]   off;
    bit          inr, hold_eff, grd, gwr;
    int          idx;
    logic [15:0] d;
    #4;
    off      = addr - BASE;
    inr      = (addr >= BASE) && ((off >> 1) < (32'd1 << AW));
    idx      = int'(off >> 1);
    hold_eff = hold_m && lock;
    grd      = rd && (!inr || hold_eff || !wr || starve_m < SLIM);
    gwr      = wr && !hold_eff && !(grd && inr);
    obs_rdw  = rd_wait;
    obs_wrw  = wr_wait;
    check("rd_waitrequest", 32'(rd_wait), 32'(rd && !grd));
    check("wr_waitrequest", 32'(wr_wait), 32'(wr && !gwr));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("readdatavalid", 32'(rdv), 32'd1);
      last_m = exp_q[0].data;
      void'(exp_q.pop_front());
    end else begin
      check("readdatavalid", 32'(rdv), 32'd0);
    end
    check("readdata", 32'(rdata), 32'(last_m));
    if (rdv) begin
      seen_d.push_back(rdata);
      seen_c.push_back(cyc);
    end
    if (grd) begin
      if (inr) d = mem_m.exists(idx) ? mem_m[idx] : 16'h0000;
      else     d = FILL;
      exp_q.push_back('{cyc + LAT, d});
      acc_c.push_back(cyc);
      reads_m++;
    end
    if (rd && !grd) stalls_m++;
    if (gwr) begin
      d = mem_m.exists(int'(wr_addr)) ? mem_m[int'(wr_addr)] : 16'h0000;
      if (be[0]) d[7:0]  = wdata[7:0];
      if (be[1]) d[15:8] = wdata[15:8];
      mem_m[int'(wr_addr)] = d;
    end
    hold_m = lock && (hold_m || grd);
    if (!wr || gwr)          starve_m = 0;
    else if (starve_m < SLIM) starve_m++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #4;
    check("reset_readdatavalid", 32'(rdv), 32'd0);
    check("reset_readdata", 32'(rdata), 32'd0);
    check("reset_rd_waitrequest", 32'(rd_wait), 32'd0);
    check("reset_wr_waitrequest", 32'(wr_wait), 32'd0);
    exp_q.delete();
    hold_m = 1'b0; starve_m = 0; last_m = '0; reads_m = 0; stalls_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  task automatic clear_seen();
    seen_d.delete(); seen_c.delete(); acc_c.delete();
  endtask

  task automatic drain(input int n);
    set_idle();
    repeat (n) step();
  endtask

  function automatic logic [31:0] px_addr(input int idx);
    return BASE + 32'(idx) * 32'd2;
  endfunction

  function automatic logic [31:0] rand_oor_addr();
    case ($urandom_range(0, 3))
      0:       return BASE - 32'd2 - 32'($urandom_range(0, 64));
      1:       return BASE + 32'h0004_0000 + 32'($urandom_range(0, 255));
      2:       return 32'hFFFF_FFFE;
      default: return 32'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] b2b[3];
    int n, grants;
    b2b[0] = 16'h1234; b2b[1] = 16'h5678; b2b[2] = 16'h9ABC;
    errors = 0; checks = 0; cyc = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Preload idx 0..63 so every later read hits known contents.
    for (int i = 0; i < 64; i++) begin
      wr = 1'b1; be = 2'b11; wr_addr = AW'(i);
      wdata = (i < 3) ? b2b[i] : 16'($urandom);
      step();
    end
    drain(1);

    // Back-to-back reads of idx 0,1,2.
    clear_seen();
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; addr = px_addr(i);
      step();
      check("b2b_no_wait", 32'(obs_rdw), 32'd0);
    end
    drain(4);
    check("b2b_count", 32'(seen_d.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_data", (i < seen_d.size()) ? 32'(seen_d[i]) : 32'hDEAD_BEEF, 32'(b2b[i]));
      check("b2b_latency", (i < seen_c.size()) ? 32'(seen_c[i] - acc_c[i]) : 32'hDEAD_BEEF, 32'(LAT));
    end

    // Out-of-range reads with a concurrent write.
    clear_seen();
    rd = 1'b1; addr = 32'h0804_0000; wr = 1'b1; wr_addr = AW'(50); wdata = 16'h5A5A;
    step();
    check("oor_hi_no_wait", 32'(obs_rdw), 32'd0);
    check("oor_hi_wr_granted", 32'(obs_wrw), 32'd0);
    addr = 32'h07FF_FFFE; wr_addr = AW'(51); wdata = 16'hA5A5;
    step();
    check("oor_lo_no_wait", 32'(obs_rdw), 32'd0);
    check("oor_lo_wr_granted", 32'(obs_wrw), 32'd0);
    drain(4);
    check("oor_count", 32'(seen_d.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      check("oor_data", (i < seen_d.size()) ? 32'(seen_d[i]) : 32'hDEAD_BEEF, 32'(FILL));
      check("oor_latency", (i < seen_c.size()) ? 32'(seen_c[i] - acc_c[i]) : 32'hDEAD_BEEF, 32'(LAT));
    end

    // Write starvation bound.
    drain(1);
    rd = 1'b1; addr = px_addr(3); wr = 1'b1; wr_addr = AW'(40); wdata = 16'hBEEF;
    n = 0;
    do begin
      step();
      n++;
    end while (obs_wrw && n < 20);
    check("starve_cycles_to_grant", 32'(n), 32'(SLIM + 1));
    check("starve_read_stalled", 32'(obs_rdw), 32'd1);
    step();
    check("starve_reset_read_ok", 32'(obs_rdw), 32'd0);
    check("starve_reset_write_waits", 32'(obs_wrw), 32'd1);
    drain(4);

    // Lock blocks writes until released.
    rd = 1'b1; lock = 1'b1; addr = px_addr(4); wr = 1'b1; wr_addr = AW'(41); wdata = 16'hC0DE;
    grants = 0;
    repeat (20) begin
      step();
      if (!obs_wrw) grants++;
    end
    check("lock_write_grants", 32'(grants), 32'd0);
    rd = 1'b0; lock = 1'b0;
    step();
    check("lock_release_write_granted", 32'(obs_wrw), 32'd0);
    drain(4);

    // Byte-enable merge at idx 5.
    clear_seen();
    wr = 1'b1; wr_addr = AW'(5); wdata = 16'hFFFF; be = 2'b11;
    step();
    wdata = 16'h00AA; be = 2'b01;
    step();
    wr = 1'b0; rd = 1'b1; addr = px_addr(5);
    step();
    drain(4);
    check("byteenable_data", (seen_d.size() > 0) ? 32'(seen_d[0]) : 32'hDEAD_BEEF, 32'h0000_FFAA);

    // Reset with two reads in flight.
    rd = 1'b1; addr = px_addr(0);
    step();
    addr = px_addr(1);
    step();
    do_reset();
    clear_seen();
    drain(5);
    check("post_reset_no_beats", 32'(seen_d.size()), 32'd0);
    check("post_reset_readdata", 32'(rdata), 32'd0);
    rd = 1'b1; addr = px_addr(2);
    step();
    drain(4);
    check("post_reset_read", (seen_d.size() > 0) ? 32'(seen_d[0]) : 32'hDEAD_BEEF, 32'h0000_9ABC);
    check("post_reset_latency", (seen_c.size() > 0) ? 32'(seen_c[0] - acc_c[0]) : 32'hDEAD_BEEF, 32'(LAT));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rd   = ($urandom_range(0, 1) == 1);
      addr = ($urandom_range(0, 4) == 0) ? rand_oor_addr()
                                         : px_addr($urandom_range(0, 63)) + 32'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) lock = ~lock;
      wr      = ($urandom_range(0, 2) != 0);
      wr_addr = AW'($urandom_range(0, 63));
      wdata   = 16'($urandom);
      be      = 2'($urandom_range(0, 3));
      step();
    end
    drain(6);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
`ifdef PIXEL_RESPONDER_STATS_EN
    check("stat_reads", stat_reads, 32'(reads_m));
    check("stat_read_stalls", stat_read_stalls, 32'(stalls_m));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
